// File: rtl/axi_rd_slv_mem.sv
// axi_rd_slv_mem: AXI read-only slave over an internal word memory; AR in, R out, pl_* backdoor preload write port
module axi_rd_slv_mem #(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 128,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ID_W-1:0]              ARID,
  input  logic [ADDR_W-1:0]            ARADDR,
  input  logic [7:0]                   ARLEN,
  input  logic [2:0]                   ARSIZE,
  input  logic [1:0]                   ARBURST,
  input  logic [3:0]                   ARREGION,
  input  logic                         ARVALID,
  output logic                         ARREADY,
  output logic [ID_W-1:0]              RID,
  output logic [DATA_W-1:0]            RDATA,
  output logic [1:0]                   RRESP,
  output logic                         RLAST,
  output logic                         RVALID,
  input  logic                         RREADY,
  input  logic                         pl_wen,
  input  logic [$clog2(MEM_DEPTH)-1:0] pl_idx,
  input  logic [DATA_W-1:0]            pl_wdata
);
  localparam int OFF = $clog2(DATA_W / 8);
  localparam int PIW = $clog2(MEM_DEPTH);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [ADDR_W-1:0] addr_q, ld_addr, ld_idx;
  logic [7:0] len_q, cnt, ld_cnt;
  logic fixed_q, err_q, ar_hs, r_hs, ld, ld_err, ld_last, in_rng, bad, pl_ok;
  logic unused;
  assign unused = ^ARREGION;
  generate
    if ((1 << PIW) > MEM_DEPTH) begin : g_chk
      assign pl_ok = pl_idx < PIW'(MEM_DEPTH);
    end else begin : g_full
      assign pl_ok = 1'b1;
    end
  endgenerate
  always_comb begin
    ARREADY  = state == IDLE;
    RVALID   = state == BURST;
    ar_hs    = ARREADY && ARVALID;
    r_hs     = RVALID && RREADY;
    state_nx = ar_hs ? BURST : (r_hs && RLAST) ? IDLE : state;
  end
  always_comb begin
    bad     = (ARBURST != 2'b00 && ARBURST != 2'b01) || ARSIZE != 3'(OFF);
    ld      = ar_hs || (r_hs && !RLAST);
    ld_addr = ar_hs ? ARADDR : fixed_q ? addr_q : addr_q + ADDR_W'(DATA_W / 8);
    ld_err  = ar_hs ? bad : err_q;
    ld_cnt  = ar_hs ? 8'd0 : cnt + 8'd1;
    ld_last = ld_cnt == (ar_hs ? ARLEN : len_q);
    ld_idx  = ld_addr >> OFF;
    in_rng  = ld_idx < ADDR_W'(MEM_DEPTH);
  end
  always_ff @(posedge clk)
    if (pl_wen && pl_ok) mem[pl_idx] <= pl_wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      RID     <= '0;
      RDATA   <= '0;
      RRESP   <= '0;
      RLAST   <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt     <= '0;
      fixed_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (ar_hs) begin
        RID     <= ARID;
        len_q   <= ARLEN;
        fixed_q <= ARBURST == 2'b00;
        err_q   <= bad;
      end
      if (ld) begin
        addr_q <= ld_addr;
        cnt    <= ld_cnt;
        RLAST  <= ld_last;
        RRESP  <= ld_err ? 2'b10 : !in_rng ? 2'b11 : 2'b00;
        RDATA  <= (ld_err || !in_rng) ? '0 : mem[ld_idx[PIW-1:0]];
      end
    end
  end
endmodule

// File: tb/tb_axi_rd_slv_mem.sv
// tb_axi_rd_slv_mem: randomized self-checking bench for axi_rd_slv_mem against a word-array reference model
module tb_axi_rd_slv_mem;
  logic clk = 0, rst = 1;
  logic [3:0] ARID = 0, ARREGION = 0;
  logic [31:0] ARADDR = 0;
  logic [7:0] ARLEN = 0;
  logic [2:0] ARSIZE = 0;
  logic [1:0] ARBURST = 0, RRESP;
  logic ARVALID = 0, ARREADY, RLAST, RVALID, RREADY = 0, pl_wen = 0;
  logic [3:0] RID;
  logic [127:0] RDATA, pl_wdata = 0;
  logic [9:0] pl_idx = 0;
  logic [127:0] mdl [1024];
  int total = 0, bad = 0;
  axi_rd_slv_mem dut (
    .clk(clk), .rst(rst), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .pl_wen(pl_wen), .pl_idx(pl_idx), .pl_wdata(pl_wdata)
  );
  always #5 clk = ~clk;
  function automatic logic [129:0] expect_beat(input logic [31:0] addr, input int i,
                                               input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a, w;
    logic [1:0] r;
    a = burst == 2'b01 ? addr + 32'(i) * 32'd16 : addr;
    w = a / 16;
    r = (burst > 2'b01 || size != 3'd4) ? 2'b10 : w >= 1024 ? 2'b11 : 2'b00;
    return {r, r != 2'b00 ? 128'd0 : mdl[w[9:0]]};
  endfunction
  task automatic pl_write(input logic [9:0] i, input logic [127:0] d);
    pl_wen = 1; pl_idx = i; pl_wdata = d;
    @(posedge clk); #1;
    pl_wen = 0;
    mdl[i] = d;
  endtask
  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode,
                           input bit pl_en, input logic [9:0] pl_i, input logic [127:0] pl_d,
                           input int abort_after);
    logic [129:0] e [256];
    logic [134:0] prev;
    bit rdy, stalled;
    int got, cyc;
    total++;
    if (ARREADY !== 1'b1) begin bad++; $display("FAIL ar_idle: ARREADY=%b want 1", ARREADY); end
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
    ARREGION = 4'($urandom); ARVALID = 1;
    if (pl_en) begin pl_wen = 1; pl_idx = pl_i; pl_wdata = pl_d; end
    e[0] = expect_beat(addr, 0, size, burst);
    if (pl_en) mdl[pl_i] = pl_d;
    for (int i = 1; i <= int'(len); i++) e[i] = expect_beat(addr, i, size, burst);
    @(posedge clk); #1;
    ARVALID = 0; pl_wen = 0;
    total++;
    if (RVALID !== 1'b1 || ARREADY !== 1'b0) begin
      bad++; $display("FAIL ar_latency: RVALID=%b ARREADY=%b want 1 0", RVALID, ARREADY);
    end
    got = 0; cyc = 0; stalled = 0; prev = '0;
    while (got <= int'(len) && cyc < 2000) begin
      rdy = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      RREADY = rdy;
      total++;
      if (RVALID !== 1'b1 || ARREADY !== 1'b0) begin
        bad++; $display("FAIL in_burst beat %0d: RVALID=%b ARREADY=%b want 1 0", got, RVALID, ARREADY);
      end
      if (stalled) begin
        total++;
        if ({RID, RDATA, RRESP, RLAST} !== prev) begin
          bad++; $display("FAIL hold beat %0d: got %h want %h", got, {RID, RDATA, RRESP, RLAST}, prev);
        end
      end
      if (rdy) begin
        total++;
        if (RID !== id || RDATA !== e[got][127:0] || RRESP !== e[got][129:128] || RLAST !== (got == int'(len))) begin
          bad++;
          $display("FAIL beat %0d: id=%h data=%h resp=%0d last=%b want id=%h data=%h resp=%0d last=%b",
                   got, RID, RDATA, RRESP, RLAST, id, e[got][127:0], e[got][129:128], got == int'(len));
        end
        got++;
      end
      stalled = !rdy;
      prev = {RID, RDATA, RRESP, RLAST};
      @(posedge clk); #1;
      cyc++;
      if (abort_after > 0 && got == abort_after) break;
    end
    RREADY = 0;
    if (abort_after == 0) begin
      total++;
      if (got != int'(len) + 1) begin bad++; $display("FAIL beat_count: got %0d want %0d", got, int'(len) + 1); end
      total++;
      if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
        bad++; $display("FAIL ar_return: ARREADY=%b RVALID=%b want 1 0", ARREADY, RVALID);
      end
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    total++;
    if (ARREADY !== 1'b1 || RVALID !== 1'b0 || RLAST !== 1'b0 || RRESP !== 2'b00 || RID !== 4'h0 || RDATA !== 128'd0) begin
      bad++;
      $display("FAIL %s: ARREADY=%b RVALID=%b RLAST=%b RRESP=%0d RID=%h RDATA=%h want 1 0 0 0 0 0",
               tag, ARREADY, RVALID, RLAST, RRESP, RID, RDATA);
    end
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 0;
  endtask
  task automatic test_preload();
    for (int i = 0; i < 1024; i++) pl_write(10'(i), {$urandom, $urandom, $urandom, $urandom});
    pl_write(10'd0, 128'hAAAA_0000_1111_2222_3333_4444_5555_0000);
    pl_write(10'd1, 128'hBBBB_0000_1111_2222_3333_4444_5555_0001);
    pl_write(10'd2, 128'hCCCC_0000_1111_2222_3333_4444_5555_0002);
    pl_write(10'd3, 128'hDDDD_0000_1111_2222_3333_4444_5555_0003);
  endtask
  task automatic test_incr();
    run_burst(4'h3, 32'h0, 8'd3, 3'd4, 2'b01, 0, 0, 0, 0, 0);
  endtask
  task automatic test_stall();
    run_burst(4'h5, 32'h0, 8'd3, 3'd4, 2'b01, 1, 0, 0, 0, 0);
  endtask
  task automatic test_fixed();
    run_burst(4'h7, 32'h20, 8'd2, 3'd4, 2'b00, 0, 0, 0, 0, 0);
  endtask
  task automatic test_decerr();
    run_burst(4'h9, 32'(1022 * 16), 8'd3, 3'd4, 2'b01, 2, 0, 0, 0, 0);
  endtask
  task automatic test_slverr();
    run_burst(4'hA, 32'h40, 8'd1, 3'd4, 2'b10, 0, 0, 0, 0, 0);
    run_burst(4'hB, 32'h40, 8'd1, 3'd4, 2'b11, 2, 0, 0, 0, 0);
    run_burst(4'hC, 32'(1023 * 16), 8'd2, 3'd3, 2'b01, 0, 0, 0, 0, 0);
  endtask
  task automatic test_collision();
    run_burst(4'h6, 32'(5 * 16), 8'd1, 3'd4, 2'b00, 0, 1, 10'd5, {4{32'hFEED_BEEF}}, 0);
  endtask
  task automatic test_reset_mid();
    run_burst(4'hE, 32'h0, 8'd3, 3'd4, 2'b01, 0, 0, 0, 0, 2);
    rst = 1; RREADY = 1;
    @(posedge clk); #1;
    check_reset_outputs("reset_mid");
    rst = 0; RREADY = 0;
    run_burst(4'h2, 32'h0, 8'd3, 3'd4, 2'b01, 0, 0, 0, 0, 0);
  endtask
  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [2:0] sz;
      logic [1:0] bt;
      sz = $urandom_range(0, 3) == 0 ? 3'($urandom) : 3'd4;
      bt = $urandom_range(0, 4) == 0 ? 2'($urandom) : 2'($urandom_range(0, 1));
      run_burst(4'($urandom), 32'($urandom_range(0, 1100 * 16)), 8'($urandom_range(0, 9)),
                sz, bt, 2, 0, 0, 0, 0);
    end
  endtask
  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++)
      run_burst(4'(n), 32'(n * 48), 8'(n), 3'd4, 2'b01, 0, 0, 0, 0, 0);
  endtask
  initial begin
    test_reset();
    test_preload();
    test_incr();
    test_stall();
    test_fixed();
    test_decerr();
    test_slverr();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_rd_slv_mem.md
AXI_RD_SLV_MEM -- requirements
Module: axi_rd_slv_mem

Interface
REQ-001 SHALL have parameter ID_W, default 4, meaning ARID/RID width.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning ARADDR width.
REQ-003 SHALL have parameter DATA_W, default 128, meaning RDATA width; power of two, at least 32.
REQ-004 SHALL have parameter MEM_DEPTH, default 1024, meaning number of DATA_W-bit words in the internal memory.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have AR inputs: ARID [ID_W], ARADDR [ADDR_W], ARLEN [8], ARSIZE [3], ARBURST [2], ARREGION [4] (ignored), ARVALID [1].
REQ-009 SHALL have port ARREADY, output, 1 bit.
REQ-010 SHALL have R outputs: RID [ID_W], RDATA [DATA_W], RRESP [2], RLAST [1], RVALID [1].
REQ-011 SHALL have port RREADY, input, 1 bit.
REQ-012 SHALL have backdoor preload inputs: pl_wen [1], pl_idx [clog2(MEM_DEPTH)] (word index), pl_wdata [DATA_W].

Function
REQ-013 SHALL implement a two-state FSM:
- IDLE: ARREADY=1, RVALID=0.
- BURST: ARREADY=0, RVALID=1.
REQ-014 SHALL, on ARVALID&&ARREADY in IDLE, latch ARID, ARADDR, ARLEN, ARSIZE, ARBURST, go to BURST, and present beat 0 on the next cycle (1-cycle AR-to-RVALID latency).
REQ-015 SHALL hold RID, RDATA, RRESP, RLAST stable while RVALID=1 and RREADY=0.
REQ-016 SHALL complete a beat on RVALID&&RREADY; after a non-last beat the next beat SHALL be presented on the following cycle with RVALID kept high (no bubble).
REQ-017 SHALL return to IDLE after the handshake of the beat with RLAST=1; ARREADY rises the cycle after that handshake; no second AR is accepted during BURST.
REQ-018 SHALL issue exactly ARLEN+1 beats; RLAST=1 only on the beat with beat count equal to ARLEN.
REQ-019 SHALL set RID = latched ARID on every beat.
REQ-020 SHALL compute the word index as addr >> log2(DATA_W/8).
- INCR: addr advances by DATA_W/8 per beat, modulo 2^ADDR_W.
- FIXED: addr constant for all beats.
REQ-021 SHALL load RDATA into a register when a beat is loaded (at AR handshake for beat 0, at the R handshake for later beats); on a preload write to the same word in that cycle, RDATA SHALL get the old value.
REQ-022 SHALL return RRESP=2'b11 (DECERR) and RDATA=0 for any beat whose word index is at or above MEM_DEPTH; other beats of the same burst are unaffected.
REQ-023 SHALL return RRESP=2'b10 (SLVERR) and RDATA=0 on all beats when ARBURST is WRAP or reserved, or ARSIZE is not log2(DATA_W/8); SLVERR takes priority over DECERR.
REQ-024 SHALL otherwise return RRESP=2'b00 with mem[index].
REQ-025 SHALL write pl_wdata to mem[pl_idx] on pl_wen in any state; pl_idx at or above MEM_DEPTH SHALL be ignored.

Reset
REQ-026 SHALL, with rst=1 at a clock edge, force IDLE, ARREADY=1, RVALID=0, RLAST=0, RRESP=0, RID=0, RDATA=0, and clear the beat counter.
REQ-027 SHALL abort any in-flight burst on reset with no further beats; memory contents SHALL NOT be cleared by reset.
REQ-028 SHALL accept a new AR on the first edge after rst deasserts.

Verification
REQ-029 Preload mem[0..3]=A,B,C,D; AR addr 0x0, LEN=3, INCR, SIZE=4, RREADY=1 -> RVALID from the cycle after AR, RDATA A,B,C,D on 4 consecutive cycles, RLAST on beat 3, RRESP=0, ARREADY back high 1 cycle later.
REQ-030 Same burst with RREADY toggled 1,0,0,1,... -> data and RLAST held during stalls; exactly 4 beats, in order.
REQ-031 FIXED burst, addr 0x20, LEN=2 -> mem[2] returned 3 times; RLAST on the third beat.
REQ-032 INCR burst, addr (MEM_DEPTH-2)*16, LEN=3 -> beats 0-1 OKAY with data; beats 2-3 RRESP=3, RDATA=0.
REQ-033 ARBURST=WRAP, LEN=1 -> 2 beats, RRESP=2, RDATA=0; ID echoed on both beats.
REQ-034 rst asserted mid-burst after beat 1 -> RVALID=0 the next cycle; new AR after reset served correctly from the preserved memory.
